// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: widths, the FSM state encoding, the default NOP
// and the PC range check. The decode and hazard units import this package too.
package fetch_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  // A fetch is illegal when the PC is not word aligned or lies past the last word.
  function automatic logic pc_illegal(input logic [XLEN-1:0] pc,
                                      input logic [XLEN-1:0] last_pc);
    return (pc[1:0] != 2'b00) || (pc > last_pc);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: the instruction-memory read port plus the IF/ID register outputs.
interface fetch_if import fetch_pkg::*; ();

  logic [XLEN-1:0] imem_adr;
  logic [ILEN-1:0] imem_instr;
  logic [XLEN-1:0] ifid_pc;
  logic [ILEN-1:0] ifid_instr;
  logic            ifid_valid;

  modport master (
    output imem_adr,
    input  imem_instr,
    output ifid_pc,
    output ifid_instr,
    output ifid_valid
  );

  modport slave (
    input  imem_adr,
    output imem_instr,
    input  ifid_pc,
    input  ifid_instr,
    input  ifid_valid
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Invalidate beats load; with neither, contents hold.
// Invalidation replaces the instruction with a NOP but keeps the captured PC.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [ILEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            inval_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [ILEN-1:0] instr_i,
  output logic [XLEN-1:0] pc_o,
  output logic [ILEN-1:0] instr_o,
  output logic            valid_o
);

  logic [XLEN-1:0] pc_q;
  logic [ILEN-1:0] instr_q;
  logic            valid_q;

  // Pipeline register with load / hold / invalidate.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= 64'h0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (inval_i) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (load_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
      valid_q <= 1'b1;
    end else begin
      pc_q    <= pc_q;
      instr_q <= instr_q;
      valid_q <= valid_q;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and the BOOT/RUN/FAULT FSM, drives the
// instruction-memory address and feeds the IF/ID register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 64'h0,
  parameter int              MEM_BYTES = 64,
  parameter logic [ILEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  fetch_if.master         bus,
  output logic            fault,
  output logic [XLEN-1:0] fault_pc
);

  localparam logic [XLEN-1:0] LAST_PC = XLEN'(MEM_BYTES - 4);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] fault_pc_q, fault_pc_d;
  logic [XLEN-1:0] pc_plus4_s;
  logic            pc_err_s;
  logic            load_s;
  logic            inval_s;

  assign pc_plus4_s = pc_q + 64'd4;
  assign pc_err_s   = pc_illegal(pc_q, LAST_PC);

  // Next-state and IF/ID control; RUN conditions are in priority order.
  // A redirect outranks a fault because the faulting fetch is wrong-path.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    load_s     = 1'b0;
    inval_s    = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          inval_s = 1'b1;
        end else if (pc_err_s) begin
          state_d    = FAULT;
          fault_d    = 1'b1;
          fault_pc_d = pc_q;
          inval_s    = 1'b1;
        end else if (stall) begin
          inval_s = flush;
        end else if (flush) begin
          pc_d    = pc_plus4_s;
          inval_s = 1'b1;
        end else begin
          pc_d   = pc_plus4_s;
          load_s = 1'b1;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = FAULT;
      end
    endcase
  end

  // FSM, PC and sticky fault state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      fault_q    <= 1'b0;
      fault_pc_q <= 64'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load_s),
    .inval_i (inval_s),
    .pc_i    (pc_q),
    .instr_i (bus.imem_instr),
    .pc_o    (bus.ifid_pc),
    .instr_o (bus.ifid_instr),
    .valid_o (bus.ifid_valid)
  );

  assign bus.imem_adr = pc_q;
  assign fault        = fault_q;
  assign fault_pc     = fault_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit with a small byte-addressed instruction memory;
// expected records are queued when stimulus is driven and checked after the edge.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic            clk;
  logic            rst;
  logic            stall;
  logic            flush;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            fault;
  logic [XLEN-1:0] fault_pc;

  fetch_if bus ();

  fetch_unit #(
    .RESET_PC  (64'h0),
    .MEM_BYTES (64),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian instruction memory; out-of-range reads return a marker word.
  logic [7:0] mem [0:63];
  logic [5:0] rd_a;
  always @* begin
    rd_a = bus.imem_adr[5:0];
    if (bus.imem_adr <= 64'd60)
      bus.imem_instr = {mem[rd_a + 6'd3], mem[rd_a + 6'd2], mem[rd_a + 6'd1], mem[rd_a]};
    else
      bus.imem_instr = 32'hDEAD_BEEF;
  end

  typedef struct {
    logic            rst;
    logic            stall;
    logic            flush;
    logic            rv;
    logic [XLEN-1:0] rpc;
    logic [XLEN-1:0] e_adr;
    logic [XLEN-1:0] e_ifid_pc;
    logic [ILEN-1:0] e_instr;
    logic            e_valid;
    logic            e_fault;
    logic [XLEN-1:0] e_fault_pc;
  } vec_t;

  int   checks;
  int   failures;
  vec_t exp_q[$];

  function automatic vec_t mk(input logic r, input logic s, input logic f, input logic rv,
                              input logic [63:0] rpc, input logic [63:0] adr,
                              input logic [63:0] ipc, input logic [31:0] ins,
                              input logic vld, input logic flt, input logic [63:0] fpc);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.rv = rv; v.rpc = rpc;
    v.e_adr = adr; v.e_ifid_pc = ipc; v.e_instr = ins; v.e_valid = vld;
    v.e_fault = flt; v.e_fault_pc = fpc;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  // Drive one step at the falling edge, queue its expectation, check after the rising edge.
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    rst            = v.rst;
    stall          = v.stall;
    flush          = v.flush;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("imem_adr",   idx, bus.imem_adr,          e.e_adr);
    chk("ifid_pc",    idx, bus.ifid_pc,           e.e_ifid_pc);
    chk("ifid_instr", idx, 64'(bus.ifid_instr),   64'(e.e_instr));
    chk("ifid_valid", idx, 64'(bus.ifid_valid),   64'(e.e_valid));
    chk("fault",      idx, 64'(fault),            64'(e.e_fault));
    chk("fault_pc",   idx, fault_pc,              e.e_fault_pc);
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;
  vec_t tbl [19];

  initial begin
    logic [31:0] w;
    checks = 0;
    failures = 0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0;
    for (int a = 0; a < 64; a += 4) begin
      if (a == 0)      w = 32'hFFAA_FFAA;
      else if (a == 4) w = 32'hAABB_CCDD;
      else             w = 32'h1000_0000 + 32'(a);
      mem[a] = w[7:0]; mem[a+1] = w[15:8]; mem[a+2] = w[23:16]; mem[a+3] = w[31:24];
    end

    //          rst   stl   fls   rv    rpc     adr     ifid_pc ins           vld   flt   fpc
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 64'h0,  64'h0,  64'h0,  NOP,          1'b0, 1'b0, 64'h0);
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 64'h0,  64'h0,  64'h0,  NOP,          1'b0, 1'b0, 64'h0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  64'h0,  64'h0,  NOP,          1'b0, 1'b0, 64'h0);
    tbl[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  64'h4,  64'h0,  32'hFFAAFFAA, 1'b1, 1'b0, 64'h0);
    tbl[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  64'h8,  64'h4,  32'hAABBCCDD, 1'b1, 1'b0, 64'h0);
    tbl[5]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 64'h0,  64'h8,  64'h4,  32'hAABBCCDD, 1'b1, 1'b0, 64'h0);
    tbl[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 64'h0,  64'h8,  64'h4,  32'hAABBCCDD, 1'b1, 1'b0, 64'h0);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  64'hC,  64'h8,  32'h10000008, 1'b1, 1'b0, 64'h0);
    tbl[8]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 64'h20, 64'h20, 64'h8,  NOP,          1'b0, 1'b0, 64'h0);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  64'h24, 64'h20, 32'h10000020, 1'b1, 1'b0, 64'h0);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 1'b1, 64'h10, 64'h10, 64'h20, NOP,          1'b0, 1'b0, 64'h0);
    tbl[11] = mk(1'b0, 1'b0, 1'b1, 1'b0, 64'h0,  64'h14, 64'h20, NOP,          1'b0, 1'b0, 64'h0);
    tbl[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  64'h18, 64'h14, 32'h10000014, 1'b1, 1'b0, 64'h0);
    tbl[13] = mk(1'b0, 1'b1, 1'b1, 1'b0, 64'h0,  64'h18, 64'h14, NOP,          1'b0, 1'b0, 64'h0);
    tbl[14] = mk(1'b0, 1'b0, 1'b0, 1'b1, 64'h3C, 64'h3C, 64'h14, NOP,          1'b0, 1'b0, 64'h0);
    tbl[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  64'h40, 64'h3C, 32'h1000003C, 1'b1, 1'b0, 64'h0);
    tbl[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  64'h40, 64'h3C, NOP,          1'b0, 1'b1, 64'h40);
    tbl[17] = mk(1'b0, 1'b0, 1'b1, 1'b1, 64'h0,  64'h40, 64'h3C, NOP,          1'b0, 1'b1, 64'h40);
    tbl[18] = mk(1'b0, 1'b1, 1'b0, 1'b0, 64'h0,  64'h40, 64'h3C, NOP,          1'b0, 1'b1, 64'h40);

    for (int i = 0; i < 19; i++) apply(tbl[i], i);

    // Reset clears the fault; BOOT ignores a redirect; redirect beats a misaligned-PC fault.
    apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 64'h0,  64'h0, 64'h0, NOP, 1'b0, 1'b0, 64'h0), 100);
    apply(mk(1'b0, 1'b0, 1'b1, 1'b1, 64'h30, 64'h0, 64'h0, NOP, 1'b0, 1'b0, 64'h0), 101);
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 64'h6,  64'h6, 64'h0, NOP, 1'b0, 1'b0, 64'h0), 102);
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 64'h8,  64'h8, 64'h0, NOP, 1'b0, 1'b0, 64'h0), 103);
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 64'h6,  64'h6, 64'h0, NOP, 1'b0, 1'b0, 64'h0), 104);
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  64'h6, 64'h0, NOP, 1'b0, 1'b1, 64'h6), 105);
    apply(mk(1'b0, 1'b1, 1'b0, 1'b0, 64'h0,  64'h6, 64'h0, NOP, 1'b0, 1'b1, 64'h6), 106);

    // Top-of-address-space PC faults rather than wrapping into the valid range.
    apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, NOP, 1'b0, 1'b0, 64'h0), 200);
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, NOP, 1'b0, 1'b0, 64'h0), 201);
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC,
             64'h0, NOP, 1'b0, 1'b0, 64'h0), 202);
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, NOP, 1'b0, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFC), 203);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
